load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sole master of the RAM unit's second (data) port; sits between the CPU execute stage and the RAM unit.
- Accepts one load/store request at a time from the CPU via a valid/ready handshake.
- Screens each request for misalignment and out-of-range addresses, then issues a one-cycle port2 strobe.
- Waits for load data or for the fixed store (read-modify-write) latency, then returns a one-cycle response; `busy` stalls the CPU meanwhile.

Parameters:
- STORE_WAIT_CYCLES, 2: cycles after issue until the RAM's read-modify-write completes.
- TIMEOUT, 15: maximum LOAD_WAIT cycles without port2avail before a timeout response.
- ADDR_LIMIT, 32'h0002_0000: first illegal byte address (32768 words).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  cpu_word  byte address
- req_wdata  in  cpu_word  store data (low-aligned)
- req_mode  in  mem_mode  access size/extension
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  cpu_word  load result (0 for stores/faults)
- resp_fault  out  1  misaligned or out-of-range; valid with resp_valid
- resp_timeout  out  1  load timed out; valid with resp_valid
- busy  out  1  stall to CPU: state != IDLE, or accept this cycle
- port2en  out  1  RAM port2 strobe, exactly one cycle per access
- port2WEn  out  1  RAM write enable
- port2adr  out  cpu_word  RAM address
- port2i  out  cpu_word  RAM write data
- memMode  out  mem_mode  RAM access mode
- port2o  in  cpu_word  RAM load data
- port2avail  in  1  RAM load data valid

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - All outputs are 0, except req_ready = 1 once reset is released.
  - Asserting reset mid-operation aborts the access with no resp_valid and drops port2en immediately. The RAM unit shares the reset event; integration inverts polarity.
- States: IDLE, ISSUE, LOAD_WAIT, STORE_WAIT, RESP.
- IDLE:
  - req_ready = 1. Accept on req_valid & req_ready.
  - Register addr, wdata, mode and we.
  - Evaluate fault: size(mode) = 2 with addr[0] != 0; size 4 with addr[1:0] != 0; or addr + size > ADDR_LIMIT.
  - Fault → RESP with resp_fault = 1; no port2en is ever issued.
  - Otherwise → ISSUE.
- ISSUE:
  - port2en = 1 for this one cycle; port2WEn = stored we.
  - port2adr, port2i and memMode are driven from the registers.
  - Next state is LOAD_WAIT (load) or STORE_WAIT (store); the counter clears to 0.
- Port2 signals are held stable from ISSUE until the return to IDLE, and are 0 in IDLE.
- LOAD_WAIT:
  - On port2avail, capture port2o into resp_rdata → RESP.
  - Otherwise the counter increments; when counter == TIMEOUT-1 without avail → RESP with resp_timeout = 1 and rdata = 0.
  - Counter width is $clog2(TIMEOUT+1).
- STORE_WAIT: the counter increments; at counter == STORE_WAIT_CYCLES-1 → RESP.
- RESP: resp_valid = 1 for exactly one cycle → IDLE. resp_* hold their values until the next accept, then clear.
- Latency from the accept edge:
  - Load: ISSUE at +1, RAM data at +2, resp_valid at +3.
  - Store: resp_valid at +4, coincident with the RAM returning to instruction fetch.
  - Fault: resp_valid at +1.
- Back-to-back requests: the next accept is possible in the cycle after RESP, so the minimum load spacing is 4 cycles.
- req_valid arriving while not in IDLE is ignored; the CPU must hold it (busy is high).
- port2avail while not in LOAD_WAIT is ignored and flagged by an assertion in simulation.
- Only size is used in fault checks; sign/zero extension is done by the RAM unit's nibble extractor and passed through unchanged.

Decomposition:
- base package additions:
  - lsu_state enum.
  - Function mem_mode_bytes(mem_mode) returning 1/2/4.
  - Constant MEM_BYTES = 32'h0002_0000, which is the ADDR_LIMIT default.
- Sub-module lsu_access_check (combinational): inputs addr, mode; outputs misaligned, out_of_range. It is reused by the future MMIO decoder.

Test Plan:
- Word load at 0x100, memory[0x40] = 32'hDEADBEEF → port2en one cycle at +1, resp_valid at +3, rdata = 32'hDEADBEEF, fault = 0.
- Byte store of 0xAB to 0x103, then word load from 0x100 (prior 32'h11223344) → store resp at +4; load returns 32'hAB223344.
- Half-word load at 0x101 → resp_valid at +1 with resp_fault = 1, port2en never asserted, RAM untouched.
- Word load at 0x0001_FFFC is OK; at 0x0002_0000 → fault = 1.
- Force port2avail = 0 for a load → resp_timeout = 1 after 15 LOAD_WAIT cycles, rdata = 0, then req_ready = 1.
- Assert reset in STORE_WAIT → port2en/busy/resp_valid = 0 immediately; after release a fresh load completes in 3 cycles.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: CPU word, RAM access mode, LSU states
// and the access-size helper used by the alignment/range screen.
package load_store_unit_pkg;

    typedef logic [31:0] cpu_word;

    // Bit 2 marks zero-extension; the RAM unit does the extension, the LSU only needs the size.
    typedef enum logic [2:0] {
        MODE_BYTE   = 3'd0,
        MODE_HALF   = 3'd1,
        MODE_WORD   = 3'd2,
        MODE_BYTE_U = 3'd4,
        MODE_HALF_U = 3'd5
    } mem_mode;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_LOAD_WAIT,
        LSU_STORE_WAIT,
        LSU_RESP
    } lsu_state;

    localparam cpu_word MEM_BYTES = 32'h0002_0000;

    function automatic logic [2:0] mem_mode_bytes(input mem_mode mode);
        case (mode)
            MODE_HALF, MODE_HALF_U: return 3'd2;
            MODE_WORD:              return 3'd4;
            default:                return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_access_check.sv
// Combinational screen for one access: alignment against its size and whether
// the last byte touched lies below ADDR_LIMIT. Shared with the MMIO decoder.
module lsu_access_check
    import load_store_unit_pkg::*;
#(
    parameter cpu_word ADDR_LIMIT = MEM_BYTES
) (
    input  cpu_word addr_i,
    input  mem_mode mode_i,
    output logic    misaligned_o,
    output logic    out_of_range_o
);

    logic [2:0]  accessSize;
    logic [32:0] endAddr;

    // The 33-bit sum keeps accesses near 0xFFFF_FFFC from wrapping into range.
    always_comb begin
        accessSize     = mem_mode_bytes(mode_i);
        endAddr        = {1'b0, addr_i} + {30'b0, accessSize};
        misaligned_o   = ((accessSize == 3'd2) && addr_i[0]) ||
                         ((accessSize == 3'd4) && (addr_i[1:0] != 2'b00));
        out_of_range_o = endAddr > {1'b0, ADDR_LIMIT};
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sole master of the RAM data port. Accepts one CPU request at
// a time, screens it, strobes port2 once and returns a one-cycle response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int      STORE_WAIT_CYCLES = 2,
    parameter int      TIMEOUT           = 15,
    parameter cpu_word ADDR_LIMIT        = MEM_BYTES
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    req_valid,
    output logic    req_ready,
    input  logic    req_we,
    input  cpu_word req_addr,
    input  cpu_word req_wdata,
    input  mem_mode req_mode,
    output logic    resp_valid,
    output cpu_word resp_rdata,
    output logic    resp_fault,
    output logic    resp_timeout,
    output logic    busy,
    output logic    port2en,
    output logic    port2WEn,
    output cpu_word port2adr,
    output cpu_word port2i,
    output mem_mode memMode,
    input  cpu_word port2o,
    input  logic    port2avail
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state         state_q, state_d;
    cpu_word          addr_q, addr_d;
    cpu_word          wdata_q, wdata_d;
    mem_mode          mode_q, mode_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cpu_word          respRdata_q, respRdata_d;
    logic             respFault_q, respFault_d;
    logic             respTimeout_q, respTimeout_d;

    logic misaligned, outOfRange, accept, portActive;

    lsu_access_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_check (
        .addr_i         (req_addr),
        .mode_i         (req_mode),
        .misaligned_o   (misaligned),
        .out_of_range_o (outOfRange)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= LSU_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            mode_q        <= MODE_BYTE;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            respRdata_q   <= '0;
            respFault_q   <= 1'b0;
            respTimeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mode_q        <= mode_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            respRdata_q   <= respRdata_d;
            respFault_q   <= respFault_d;
            respTimeout_q <= respTimeout_d;
        end
    end

    assign req_ready = reset && (state_q == LSU_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mode_d        = mode_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        respRdata_d   = respRdata_q;
        respFault_d   = respFault_q;
        respTimeout_d = respTimeout_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    addr_d        = req_addr;
                    wdata_d       = req_wdata;
                    mode_d        = req_mode;
                    we_d          = req_we;
                    respRdata_d   = '0;
                    respFault_d   = misaligned || outOfRange;
                    respTimeout_d = 1'b0;
                    state_d       = (misaligned || outOfRange) ? LSU_RESP : LSU_ISSUE;
                end
            end
            LSU_ISSUE: begin
                cnt_d   = '0;
                state_d = we_q ? LSU_STORE_WAIT : LSU_LOAD_WAIT;
            end
            LSU_LOAD_WAIT: begin
                if (port2avail) begin
                    respRdata_d = port2o;
                    state_d     = LSU_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    respTimeout_d = 1'b1;
                    state_d       = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_STORE_WAIT: begin
                if (cnt_q == CNT_W'(STORE_WAIT_CYCLES - 1)) begin
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // A faulted request never reaches the RAM, so the port stays quiet through its RESP cycle.
    assign portActive = (state_q == LSU_ISSUE) || (state_q == LSU_LOAD_WAIT) ||
                        (state_q == LSU_STORE_WAIT) || ((state_q == LSU_RESP) && !respFault_q);

    assign port2en      = (state_q == LSU_ISSUE);
    assign port2WEn     = portActive && we_q;
    assign port2adr     = portActive ? addr_q : '0;
    assign port2i       = portActive ? wdata_q : '0;
    assign memMode      = portActive ? mode_q : MODE_BYTE;
    assign busy         = (state_q != LSU_IDLE) || accept;
    assign resp_valid   = (state_q == LSU_RESP);
    assign resp_rdata   = respRdata_q;
    assign resp_fault   = respFault_q;
    assign resp_timeout = respTimeout_q;

    availOnlyInLoadWait: assert property (@(posedge clk) disable iff (!reset)
        port2avail |-> (state_q == LSU_LOAD_WAIT));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small behavioural
// model of the RAM data port (store at strobe, load data one cycle later).
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic    clk = 1'b0;
   logic    reset = 1'b0;
   logic    req_valid = 1'b0;
   logic    req_ready;
   logic    req_we = 1'b0;
   cpu_word req_addr = '0;
   cpu_word req_wdata = '0;
   mem_mode req_mode = MODE_WORD;
   logic    resp_valid;
   cpu_word resp_rdata;
   logic    resp_fault;
   logic    resp_timeout;
   logic    busy;
   logic    port2en;
   logic    port2WEn;
   cpu_word port2adr;
   cpu_word port2i;
   mem_mode memMode;
   cpu_word port2o;
   logic    port2avail;

   logic    ramMute = 1'b0;
   logic [31:0] mem [0:1023];
   int      testsRun = 0;
   int      failures = 0;
   int      lat, enCount, enAt;
   logic    busyPre;

   load_store_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .resp_timeout(resp_timeout), .busy(busy),
      .port2en(port2en), .port2WEn(port2WEn), .port2adr(port2adr),
      .port2i(port2i), .memMode(memMode), .port2o(port2o), .port2avail(port2avail)
   );

   always #5 clk = ~clk;

   // Merge store data into the old word according to the access size and byte lane.
   function automatic logic [31:0] mergeStore(input logic [31:0] old, input logic [31:0] data,
                                              input mem_mode mode, input logic [1:0] lane);
      logic [31:0] w;
      w = old;
      case (mode)
         MODE_BYTE, MODE_BYTE_U: w[lane*8 +: 8] = data[7:0];
         MODE_HALF, MODE_HALF_U: w[lane[1]*16 +: 16] = data[15:0];
         default: w = data;
      endcase
      return w;
   endfunction

   // Memory array of the RAM model; survives LSU resets on purpose.
   always @(posedge clk) begin
      if (reset && port2en && port2WEn)
         mem[port2adr[11:2]] <= mergeStore(mem[port2adr[11:2]], port2i, memMode, port2adr[1:0]);
   end

   // Load data returns one cycle after the strobe unless the RAM is muted.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         port2avail <= 1'b0;
         port2o <= '0;
      end else begin
         port2avail <= 1'b0;
         port2o <= '0;
         if (port2en && !port2WEn && !ramMute) begin
            port2avail <= 1'b1;
            port2o <= mem[port2adr[11:2]];
         end
      end
   end

   // Every comparison funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present one request, wait for the accept edge, then time the response.
   task automatic applyStimulus(input logic we, input cpu_word addr, input cpu_word wdata,
                                input mem_mode mode, output int latency, output int strobes,
                                output int strobeAt, output logic busyBefore);
      req_valid = 1'b1;
      req_we = we;
      req_addr = addr;
      req_wdata = wdata;
      req_mode = mode;
      #1;
      busyBefore = busy;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      latency = 1;
      strobes = 0;
      strobeAt = 0;
      while (!resp_valid && latency < 40) begin
         if (port2en) begin
            strobes++;
            strobeAt = latency;
         end
         @(posedge clk);
         #1;
         latency++;
      end
      if (port2en) begin
         strobes++;
         strobeAt = latency;
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

      // Reset values while reset is held low.
      #2;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_port2en", 32'(port2en), 32'd0);
      checkOutput("rst_port2adr", port2adr, 32'd0);
      #20;
      reset = 1'b1;
      stepCycle();
      checkOutput("rel_req_ready", 32'(req_ready), 32'd1);

      // Word store 0xDEADBEEF to 0x100: strobe at +1, response at +4.
      applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, MODE_WORD, lat, enCount, enAt, busyPre);
      checkOutput("st_busy_on_accept", 32'(busyPre), 32'd1);
      checkOutput("st_latency", 32'(lat), 32'd4);
      checkOutput("st_strobes", 32'(enCount), 32'd1);
      checkOutput("st_strobe_at", 32'(enAt), 32'd1);
      checkOutput("st_port2WEn_held", 32'(port2WEn), 32'd1);
      checkOutput("st_port2adr_held", port2adr, 32'h100);
      checkOutput("st_fault", 32'(resp_fault), 32'd0);
      checkOutput("st_rdata", resp_rdata, 32'd0);
      stepCycle();
      checkOutput("st_port_idle", port2adr, 32'd0);

      // Word load from 0x100 returns the stored word at +3.
      applyStimulus(1'b0, 32'h100, 32'h0, MODE_WORD, lat, enCount, enAt, busyPre);
      checkOutput("ld_latency", 32'(lat), 32'd3);
      checkOutput("ld_strobe_at", 32'(enAt), 32'd1);
      checkOutput("ld_strobes", 32'(enCount), 32'd1);
      checkOutput("ld_rdata", resp_rdata, 32'hDEADBEEF);
      checkOutput("ld_fault", 32'(resp_fault), 32'd0);
      stepCycle();
      checkOutput("ld_rdata_holds", resp_rdata, 32'hDEADBEEF);

      // Word store 0x11223344, byte store 0xAB to lane 3, then read back the merge.
      applyStimulus(1'b1, 32'h100, 32'h11223344, MODE_WORD, lat, enCount, enAt, busyPre);
      stepCycle();
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = 32'h103;
      req_wdata = 32'h000000AB;
      req_mode = MODE_BYTE;
      stepCycle();
      req_valid = 1'b0;
      checkOutput("bst_memMode", 32'(memMode), 32'(MODE_BYTE));
      checkOutput("bst_port2i", port2i, 32'hAB);
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("bst_resp_at_4", 32'(resp_valid), 32'd1);
      stepCycle();
      applyStimulus(1'b0, 32'h100, 32'h0, MODE_WORD, lat, enCount, enAt, busyPre);
      checkOutput("merge_rdata", resp_rdata, 32'hAB223344);
      stepCycle();

      // Misaligned half-word load faults at +1 and never strobes the RAM.
      applyStimulus(1'b0, 32'h101, 32'h0, MODE_HALF, lat, enCount, enAt, busyPre);
      checkOutput("mis_latency", 32'(lat), 32'd1);
      checkOutput("mis_fault", 32'(resp_fault), 32'd1);
      checkOutput("mis_strobes", 32'(enCount), 32'd0);
      checkOutput("mis_port2adr", port2adr, 32'd0);
      stepCycle();

      // Last legal word versus first illegal address.
      applyStimulus(1'b0, 32'h0001_FFFC, 32'h0, MODE_WORD, lat, enCount, enAt, busyPre);
      checkOutput("edge_ok_fault", 32'(resp_fault), 32'd0);
      checkOutput("edge_ok_latency", 32'(lat), 32'd3);
      stepCycle();
      applyStimulus(1'b0, 32'h0002_0000, 32'h0, MODE_WORD, lat, enCount, enAt, busyPre);
      checkOutput("oor_fault", 32'(resp_fault), 32'd1);
      checkOutput("oor_strobes", 32'(enCount), 32'd0);
      stepCycle();
      applyStimulus(1'b0, 32'h0001_FFFF, 32'h0, MODE_BYTE_U, lat, enCount, enAt, busyPre);
      checkOutput("last_byte_fault", 32'(resp_fault), 32'd0);
      stepCycle();

      // Muted RAM: timeout after 15 LOAD_WAIT cycles, response at +17.
      ramMute = 1'b1;
      applyStimulus(1'b0, 32'h100, 32'h0, MODE_WORD, lat, enCount, enAt, busyPre);
      ramMute = 1'b0;
      checkOutput("to_latency", 32'(lat), 32'd17);
      checkOutput("to_timeout", 32'(resp_timeout), 32'd1);
      checkOutput("to_rdata", resp_rdata, 32'd0);
      checkOutput("to_fault", 32'(resp_fault), 32'd0);
      stepCycle();
      checkOutput("to_ready_after", 32'(req_ready), 32'd1);

      // Reset during STORE_WAIT aborts immediately; a fresh load then completes in 3.
      applyStimulus(1'b1, 32'h200, 32'h55, MODE_WORD, lat, enCount, enAt, busyPre);
      stepCycle();
      req_valid = 1'b0;
      req_we = 1'b1;
      req_addr = 32'h204;
      req_mode = MODE_WORD;
      req_valid = 1'b1;
      stepCycle();
      req_valid = 1'b0;
      stepCycle();
      checkOutput("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("abort_port2en", 32'(port2en), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("abort_port2WEn", 32'(port2WEn), 32'd0);
      stepCycle();
      reset = 1'b1;
      stepCycle();
      applyStimulus(1'b0, 32'h100, 32'h0, MODE_WORD, lat, enCount, enAt, busyPre);
      checkOutput("post_rst_latency", 32'(lat), 32'd3);
      checkOutput("post_rst_rdata", resp_rdata, 32'hAB223344);
      checkOutput("post_rst_timeout", 32'(resp_timeout), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
